// File: rtl/phy_rx_pkg.sv
// Shared types and defaults for the two-lane PHY RX alignment controller.
package phy_rx_pkg;

    localparam logic [7:0] COM_SYM_DEF = 8'hBC;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_DESKEW = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } top_st_e;

    typedef enum logic [1:0] {
        LN_SEARCH  = 2'd0,
        LN_LOCKING = 2'd1,
        LN_LOCKED  = 2'd2
    } lane_st_e;

endpackage

// File: rtl/phy_rx_lane_align.sv
// Per-lane COM hunter: finds byte alignment and tracks byte boundaries.
module phy_rx_lane_align
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COM_SYM   = COM_SYM_DEF,
    parameter int         COM_COUNT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic restart_i,
    input  logic data_i,
    output logic lock_o,
    output logic bnd_o
);

    lane_st_e   st_q, st_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_q, bit_d;
    logic [3:0] com_q, com_d;
    logic       hit;

    assign sr_d = {sr_q[6:0], data_i};
    assign hit  = (sr_q == COM_SYM);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q  <= LN_SEARCH;
            sr_q  <= '0;
            bit_q <= '0;
            com_q <= '0;
        end else begin
            st_q  <= st_d;
            sr_q  <= sr_d;
            bit_q <= bit_d;
            com_q <= com_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        bit_d = bit_q + 3'd1;
        com_d = com_q;
        if (!en_i || restart_i) begin
            st_d  = LN_SEARCH;
            bit_d = '0;
            com_d = '0;
        end else begin
            unique case (st_q)
                LN_SEARCH: begin
                    bit_d = '0;
                    if (hit) begin
                        com_d = 4'd1;
                        st_d  = (COM_COUNT == 1) ? LN_LOCKED
                                                 : LN_LOCKING;
                    end
                end
                LN_LOCKING: begin
                    // bit_q==7 means sr_q holds a complete aligned byte
                    if (bit_q == 3'd7) begin
                        if (hit) begin
                            com_d = com_q + 4'd1;
                            if (com_q + 4'd1 == 4'(COM_COUNT))
                                st_d = LN_LOCKED;
                        end else begin
                            com_d = '0;
                            st_d  = LN_SEARCH;
                        end
                    end
                end
                LN_LOCKED: ;
                default: st_d = LN_SEARCH;
            endcase
        end
    end

    always_comb begin
        lock_o = (st_q == LN_LOCKED);
        bnd_o  = (st_q != LN_SEARCH) && (bit_q == 3'd0);
    end

endmodule

// File: rtl/phy_rx_align_ctrl.sv
// Two-lane RX alignment: per-lane lock, skew measurement, deskew setup
// and reception enable.
module phy_rx_align_ctrl
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COM_SYM   = COM_SYM_DEF,
    parameter int         COM_COUNT = 4,
    parameter int         MAX_SKEW  = 7,
    parameter int         DEPTH_W   = 3
) (
    input  logic               clk_32f,
    input  logic               reset,
    input  logic               rx_en,
    input  logic               data_in_0,
    input  logic               data_in_1,
    output logic [1:0]         lane_lock,
    output logic               deskew_lane,
    output logic [DEPTH_W-1:0] deskew_depth,
    output logic               rx_active,
    output logic               byte_tick,
    output logic               align_err
);

    localparam logic [DEPTH_W:0] SKEW_LIM = (DEPTH_W+1)'(MAX_SKEW);

    top_st_e            st_q, st_d;
    logic               early_q, early_d;
    logic [DEPTH_W-1:0] skew_q, skew_d;
    logic               dl_q, dl_d;
    logic [DEPTH_W-1:0] dd_q, dd_d;
    logic [DEPTH_W:0]   skew_nx;
    logic               restart;
    logic [1:0]         bnd;

    phy_rx_lane_align #(
        .COM_SYM   (COM_SYM),
        .COM_COUNT (COM_COUNT)
    ) u_lane0 (
        .clk_i     (clk_32f),
        .rst_ni    (reset),
        .en_i      (rx_en),
        .restart_i (restart),
        .data_i    (data_in_0),
        .lock_o    (lane_lock[0]),
        .bnd_o     (bnd[0])
    );

    phy_rx_lane_align #(
        .COM_SYM   (COM_SYM),
        .COM_COUNT (COM_COUNT)
    ) u_lane1 (
        .clk_i     (clk_32f),
        .rst_ni    (reset),
        .en_i      (rx_en),
        .restart_i (restart),
        .data_i    (data_in_1),
        .lock_o    (lane_lock[1]),
        .bnd_o     (bnd[1])
    );

    assign skew_nx = {1'b0, skew_q} + 1'b1;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            st_q    <= ST_IDLE;
            early_q <= 1'b0;
            skew_q  <= '0;
            dl_q    <= 1'b0;
            dd_q    <= '0;
        end else begin
            st_q    <= st_d;
            early_q <= early_d;
            skew_q  <= skew_d;
            dl_q    <= dl_d;
            dd_q    <= dd_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        early_d = early_q;
        skew_d  = skew_q;
        dl_d    = dl_q;
        dd_d    = dd_q;
        if (!rx_en) begin
            st_d = ST_IDLE;
            dl_d = 1'b0;
            dd_d = '0;
        end else begin
            unique case (st_q)
                ST_IDLE: st_d = ST_ALIGN;
                ST_ALIGN: begin
                    if (&lane_lock) begin
                        dl_d = 1'b0;
                        dd_d = '0;
                        st_d = ST_ACTIVE;
                    end else if (|lane_lock) begin
                        early_d = lane_lock[1];
                        skew_d  = '0;
                        st_d    = ST_DESKEW;
                    end
                end
                ST_DESKEW: begin
                    skew_d = skew_q + 1'b1;
                    if (lane_lock[~early_q]) begin
                        dl_d = early_q;
                        dd_d = skew_nx[DEPTH_W-1:0];
                        st_d = ST_ACTIVE;
                    end else if (skew_nx >= SKEW_LIM) begin
                        // a lock next cycle would already be out of range
                        st_d = ST_ERROR;
                    end
                end
                ST_ACTIVE: ;
                ST_ERROR: begin
                    dl_d = 1'b0;
                    dd_d = '0;
                    st_d = ST_ALIGN;
                end
                default: st_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_active    = (st_q == ST_ACTIVE);
        align_err    = (st_q == ST_ERROR);
        restart      = align_err;
        deskew_lane  = dl_q;
        deskew_depth = dd_q;
        byte_tick    = rx_active && bnd[~dl_q];
    end

endmodule

// File: tb/tb_phy_rx_align_ctrl.sv
// Directed bench for phy_rx_align_ctrl with hand-computed cycle indices.
module tb_phy_rx_align_ctrl;

    logic       clk_32f   = 1'b0;
    logic       reset     = 1'b1;
    logic       rx_en     = 1'b0;
    logic       data_in_0 = 1'b0;
    logic       data_in_1 = 1'b0;
    logic [1:0] lane_lock;
    logic       deskew_lane;
    logic [2:0] deskew_depth;
    logic       rx_active;
    logic       byte_tick;
    logic       align_err;

    int n_chk  = 0;
    int n_pass = 0;

    logic s0 [0:127];
    logic s1 [0:127];
    int   lk [0:127];
    int   act[0:127];
    int   tk [0:127];
    int   er [0:127];
    int   dl [0:127];
    int   dd [0:127];

    phy_rx_align_ctrl dut (
        .clk_32f      (clk_32f),
        .reset        (reset),
        .rx_en        (rx_en),
        .data_in_0    (data_in_0),
        .data_in_1    (data_in_1),
        .lane_lock    (lane_lock),
        .deskew_lane  (deskew_lane),
        .deskew_depth (deskew_depth),
        .rx_active    (rx_active),
        .byte_tick    (byte_tick),
        .align_err    (align_err)
    );

    always #5 clk_32f = ~clk_32f;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got,
                         input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".lock"}, int'(lane_lock), 0);
        check({tag, ".act"}, int'(rx_active), 0);
        check({tag, ".dl"}, int'(deskew_lane), 0);
        check({tag, ".dd"}, int'(deskew_depth), 0);
        check({tag, ".tick"}, int'(byte_tick), 0);
        check({tag, ".err"}, int'(align_err), 0);
    endtask

    task automatic clear();
        for (int i = 0; i < 128; i++) begin
            s0[i] = 1'b0;
            s1[i] = 1'b0;
        end
    endtask

    task automatic put(input int lane, input int pos,
                       input logic [7:0] byt);
        for (int b = 0; b < 8; b++) begin
            if (lane == 0) s0[pos+b] = byt[7-b];
            else           s1[pos+b] = byt[7-b];
        end
    endtask

    task automatic put_coms(input int lane, input int pos,
                            input int n);
        for (int c = 0; c < n; c++) put(lane, pos + 8*c, 8'hBC);
    endtask

    task automatic do_reset();
        @(posedge clk_32f); #1;
        reset     = 1'b0;
        rx_en     = 1'b1;
        data_in_0 = 1'b0;
        data_in_1 = 1'b0;
        @(posedge clk_32f); #1;
        reset = 1'b1;
    endtask

    // cycle k logs outputs after edge k, then drives bit k
    task automatic play(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_32f); #1;
            lk[k]  = int'(lane_lock);
            act[k] = int'(rx_active);
            tk[k]  = int'(byte_tick);
            er[k]  = int'(align_err);
            dl[k]  = int'(deskew_lane);
            dd[k]  = int'(deskew_depth);
            data_in_0 = s0[k];
            data_in_1 = s1[k];
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        rx_en = 1'b1;
        repeat (3) @(posedge clk_32f);
        #1;
        check_zero("rst");

        // lane1 lags by 4
        clear();
        put_coms(0, 0, 4);
        put_coms(1, 4, 4);
        do_reset();
        play(60);
        check("s1.lk32", lk[32], 0);
        check("s1.lk33", lk[33], 1);
        check("s1.lk36", lk[36], 1);
        check("s1.lk37", lk[37], 3);
        check("s1.act37", act[37], 0);
        check("s1.act38", act[38], 1);
        check("s1.dd38", dd[38], 4);
        check("s1.dl38", dl[38], 0);
        check("s1.tk44", tk[44], 0);
        check("s1.tk45", tk[45], 1);
        check("s1.tk46", tk[46], 0);
        check("s1.tk53", tk[53], 1);
        check("s1.dd59", dd[59], 4);
        check("s1.act59", act[59], 1);
        rx_en = 1'b0;
        @(posedge clk_32f); #1;
        check_zero("rxen");
        rx_en = 1'b1;

        // identical lanes
        clear();
        put_coms(0, 0, 4);
        put_coms(1, 0, 4);
        do_reset();
        play(45);
        check("s2.lk32", lk[32], 0);
        check("s2.lk33", lk[33], 3);
        check("s2.act33", act[33], 0);
        check("s2.act34", act[34], 1);
        check("s2.dd34", dd[34], 0);
        check("s2.tk40", tk[40], 0);
        check("s2.tk41", tk[41], 1);

        // skew 9 -> error, then lane1 early by 2
        clear();
        put_coms(0, 0, 4);
        put_coms(1, 9, 4);
        put_coms(1, 48, 4);
        put_coms(0, 50, 4);
        do_reset();
        play(95);
        check("s3.lk33", lk[33], 1);
        check("s3.er40", er[40], 0);
        check("s3.er41", er[41], 1);
        check("s3.er42", er[42], 0);
        check("s3.lk41", lk[41], 1);
        check("s3.lk42", lk[42], 0);
        check("s3.act42", act[42], 0);
        check("s3.lk81", lk[81], 2);
        check("s3.lk83", lk[83], 3);
        check("s3.act83", act[83], 0);
        check("s3.act84", act[84], 1);
        check("s3.dl84", dl[84], 1);
        check("s3.dd84", dd[84], 2);
        check("s3.tk89", tk[89], 0);
        check("s3.tk91", tk[91], 1);

        // broken preamble
        clear();
        for (int ln = 0; ln < 2; ln++) begin
            put_coms(ln, 0, 3);
            put(ln, 24, 8'hAA);
            put_coms(ln, 32, 4);
        end
        do_reset();
        play(70);
        check("s4.lk33", lk[33], 0);
        check("s4.lk40", lk[40], 0);
        check("s4.lk64", lk[64], 0);
        check("s4.lk65", lk[65], 3);
        check("s4.act66", act[66], 1);

        // reset mid-DESKEW
        clear();
        put_coms(0, 0, 4);
        put_coms(1, 9, 4);
        do_reset();
        play(36);
        check("s5.lk35", lk[35], 1);
        reset = 1'b0;
        #1;
        check_zero("s5.rst");

        // 3-bit offset
        clear();
        put_coms(0, 3, 4);
        put_coms(1, 3, 4);
        do_reset();
        play(50);
        check("s6.lk35", lk[35], 0);
        check("s6.lk36", lk[36], 3);
        check("s6.act37", act[37], 1);
        check("s6.tk43", tk[43], 0);
        check("s6.tk44", tk[44], 1);
        check("s6.tk45", tk[45], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/phy_rx_align_ctrl.md
Name: phy_rx_align_ctrl

Overview:
Receive-side alignment controller for the two-lane PCIe PHY RX path, clocked at clk_32f.
- Hunts for the COM symbol (0xBC, MSB first) independently on each serial lane.
- Declares per-lane byte lock after COM_COUNT consecutive COMs.
- Measures lane-to-lane skew and programs the deskew delay selection.
- Once both lanes are aligned, enables data reception (rx_active) and provides the byte strobe.

Parameters:
COM_SYM, 8'hBC, comma symbol that opens reception
COM_COUNT, 4, consecutive byte-aligned COMs required for lane lock (range 1..15)
MAX_SKEW, 7, largest tolerated lane-to-lane skew in clk_32f cycles
DEPTH_W, 3, width of deskew_depth; must satisfy 2^DEPTH_W > MAX_SKEW

Ports:
clk_32f  in  1  bit clock; all logic on its rising edge
reset  in  1  asynchronous, active-low reset
rx_en  in  1  enable; low forces IDLE
data_in_0  in  1  serial lane 0, MSB first
data_in_1  in  1  serial lane 1, MSB first
lane_lock  out  2  per-lane byte lock, registered
deskew_lane  out  1  lane to delay (the earlier lane)
deskew_depth  out  DEPTH_W  delay in cycles applied to deskew_lane
rx_active  out  1  both lanes aligned and deskew programmed; gates valid_out in the datapath
byte_tick  out  1  one-cycle pulse at each byte boundary of the later lane; only while rx_active
align_err  out  1  one-cycle pulse when skew exceeds MAX_SKEW

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0.
  - Shift registers, counters and timers cleared.
  - Top FSM in IDLE; both lane FSMs in SEARCH.
- Per-lane aligner:
  - 8-bit shift register, shifted left with the new bit in the LSB each cycle.
  - SEARCH: when the shift register equals COM_SYM, set com_cnt=1 and bit_cnt=0, then go to LOCKING.
  - LOCKING: bit_cnt increments mod 8. When bit_cnt wraps to 0 (byte boundary):
    - shift register == COM_SYM: com_cnt++. If com_cnt reaches COM_COUNT, go to LOCKED.
    - otherwise: return to SEARCH with com_cnt=0. A new COM is not searched for in that same cycle.
  - LOCKED: lane_lock[i] is 1 from the cycle after the COM_COUNT-th COM is completed. bit_cnt keeps running so byte boundaries stay tracked.
  - restart (from the top FSM) or rx_en=0: forces SEARCH and clears lane_lock[i] next cycle.
- Top FSM states IDLE, ALIGN, DESKEW, ACTIVE, ERROR:
  - IDLE: leave for ALIGN when rx_en=1.
  - ALIGN: wait for the first lane_lock bit.
    - Both bits rise in the same cycle: deskew_lane=0, deskew_depth=0, go to ACTIVE.
    - One bit rises: record the early lane, clear skew_cnt, go to DESKEW.
  - DESKEW: skew_cnt increments every cycle.
    - Other lane locks: deskew_lane = early lane, deskew_depth = skew_cnt+1 (equal to the difference in lock-assert cycles), go to ACTIVE.
    - skew_cnt+1 exceeds MAX_SKEW first: go to ERROR.
  - ERROR: align_err=1 for exactly one cycle and restart pulsed to both lanes. Next cycle go to ALIGN, with deskew_depth and deskew_lane cleared.
  - ACTIVE: rx_active=1 and deskew outputs held stable. byte_tick pulses in each cycle where the later lane's bit_cnt==0.
- rx_en=0 in any state: next cycle IDLE, rx_active=0, lane_lock=0. deskew outputs are cleared.
- Lock is not revalidated in ACTIVE, since the data payload is arbitrary. It is held until rx_en drops or reset is asserted.
- Reset asserted mid-operation: immediate return to reset values regardless of state.
- The early lane's lock is retained through DESKEW; only ERROR or rx_en clears it.

Decomposition:
- Shared package phy_rx_pkg holds:
  - COM_SYM default;
  - top FSM state encoding (IDLE=0, ALIGN=1, DESKEW=2, ACTIVE=3, ERROR=4);
  - lane FSM encoding (SEARCH, LOCKING, LOCKED).
- One sub-module, phy_rx_lane_align, implements the per-lane aligner (shift register, bit_cnt, com_cnt, lane FSM). It is instantiated twice.
- Skew timer and top FSM live in phy_rx_align_ctrl.

Test Plan:
- Four COMs (1,0,1,1,1,1,0,0 each) on lane 0, with lane 1 carrying the same stream delayed by 4 cycles -> lane_lock[0] rises 4 cycles before lane_lock[1]; deskew_lane=0, deskew_depth=4, rx_active=1 the cycle after lane_lock[1]; byte_tick every 8 cycles.
- Identical streams on both lanes -> both locks in the same cycle, deskew_depth=0, rx_active next cycle.
- Lane 1 delayed 9 cycles -> align_err one-cycle pulse 8 cycles after lane_lock[0]; lane_lock cleared and FSM back in ALIGN; a following 2-cycle-skew preamble yields deskew_depth=2.
- Three COMs then 0xAA -> no lock; lane back in SEARCH; four further COMs -> lock.
- rx_en dropped while ACTIVE -> next cycle rx_active=0, lane_lock=00, outputs cleared; reset pulsed low mid-DESKEW -> all outputs 0 immediately.
- COM pattern at arbitrary bit offset (3 leading zeros) -> lock after four COMs; byte_tick aligned to COM boundaries.
